// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: channel widths, burst encoding and the packed
// payload structs used by the register slice and the SRAM FSM slave.
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif

package axi4_pkg;
  localparam int ID_W   = `AXI4_ID_WIDTH;
  localparam int ADDR_W = `AXI4_ADDR_WIDTH;
  localparam int DATA_W = `AXI4_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    axi_burst_t        burst;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    axi_burst_t        burst;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;
endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle with master/slave views. aclk/aresetn are carried for the
// benefit of other agents; the register slice clocks from its own ports.
interface axi4_if import axi4_pkg::*; (input logic aclk, input logic aresetn);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_skid_buf.sv
// Two-entry skid buffer for one valid/ready channel. Ready toward the source
// comes straight from a flop, so no combinational path links out_ready_i to
// in_ready_o. The head slot always drives the output payload.
module axi4_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);
  logic [1:0] r_cnt;
  logic       r_in_ready;
  T           r_head;
  T           r_tail;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_next;

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = (r_cnt != 2'd0);
  assign out_data_o  = r_head;
  assign w_push      = in_valid_i & r_in_ready;
  assign w_pop       = out_valid_o & out_ready_i;

  // Occupancy after this cycle's accept and release.
  always_comb begin
    w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Occupancy and registered ready; reset empties the buffer immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_cnt_next != 2'd2);
    end
  end

  // Payload slots: head follows FIFO order, tail catches the beat that
  // arrives while the head is stalled.
  always_ff @(posedge clk_i) begin
    if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop))) begin
      r_head <= in_data_i;
    end else if (w_push && (r_cnt == 2'd1)) begin
      r_tail <= in_data_i;
    end else if (w_pop && (r_cnt == 2'd2)) begin
      r_head <= r_tail;
    end
  end
endmodule

// File: rtl/axi4_sram_slice.sv
// AXI4 register slice in front of the SRAM FSM slave. Each channel is either
// a skid buffer (registered both ways, one cycle of latency) or a plain wire,
// chosen per channel. The top only packs interface fields into the payload
// structs and unpacks them on the far side.
module axi4_sram_slice import axi4_pkg::*; #(
  parameter bit CUT_AW = 1'b1,
  parameter bit CUT_W  = 1'b1,
  parameter bit CUT_AR = 1'b1,
  parameter bit CUT_R  = 1'b1,
  parameter bit CUT_B  = 1'b1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  axi4_if.slave  s_axi,
  axi4_if.master m_axi,
  output logic   busy_o
);
  aw_chan_t   w_aw_in, w_aw_out;
  w_chan_t    w_w_in,  w_w_out;
  b_chan_t    w_b_in,  w_b_out;
  ar_chan_t   w_ar_in, w_ar_out;
  r_chan_t    w_r_in,  w_r_out;
  logic [4:0] w_busy;

  assign w_aw_in = '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen,
                     size: s_axi.awsize, burst: axi_burst_t'(s_axi.awburst)};
  assign w_w_in  = '{data: s_axi.wdata, strb: s_axi.wstrb, last: s_axi.wlast};
  assign w_b_in  = '{id: m_axi.bid, resp: m_axi.bresp};
  assign w_ar_in = '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen,
                     size: s_axi.arsize, burst: axi_burst_t'(s_axi.arburst)};
  assign w_r_in  = '{id: m_axi.rid, data: m_axi.rdata, resp: m_axi.rresp,
                     last: m_axi.rlast};

  assign m_axi.awid    = w_aw_out.id;
  assign m_axi.awaddr  = w_aw_out.addr;
  assign m_axi.awlen   = w_aw_out.len;
  assign m_axi.awsize  = w_aw_out.size;
  assign m_axi.awburst = w_aw_out.burst;
  assign m_axi.wdata   = w_w_out.data;
  assign m_axi.wstrb   = w_w_out.strb;
  assign m_axi.wlast   = w_w_out.last;
  assign s_axi.bid     = w_b_out.id;
  assign s_axi.bresp   = w_b_out.resp;
  assign m_axi.arid    = w_ar_out.id;
  assign m_axi.araddr  = w_ar_out.addr;
  assign m_axi.arlen   = w_ar_out.len;
  assign m_axi.arsize  = w_ar_out.size;
  assign m_axi.arburst = w_ar_out.burst;
  assign s_axi.rid     = w_r_out.id;
  assign s_axi.rdata   = w_r_out.data;
  assign s_axi.rresp   = w_r_out.resp;
  assign s_axi.rlast   = w_r_out.last;

  assign busy_o = |w_busy;

  generate
    if (CUT_AW) begin : g_aw_cut
      axi4_skid_buf #(.T(aw_chan_t)) u_aw (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(s_axi.awvalid), .in_ready_o(s_axi.awready), .in_data_i(w_aw_in),
        .out_valid_o(m_axi.awvalid), .out_ready_i(m_axi.awready), .out_data_o(w_aw_out));
      assign w_busy[0] = m_axi.awvalid;
    end else begin : g_aw_pass
      assign m_axi.awvalid = s_axi.awvalid;
      assign s_axi.awready = m_axi.awready;
      assign w_aw_out      = w_aw_in;
      assign w_busy[0]     = 1'b0;
    end

    if (CUT_W) begin : g_w_cut
      axi4_skid_buf #(.T(w_chan_t)) u_w (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(s_axi.wvalid), .in_ready_o(s_axi.wready), .in_data_i(w_w_in),
        .out_valid_o(m_axi.wvalid), .out_ready_i(m_axi.wready), .out_data_o(w_w_out));
      assign w_busy[1] = m_axi.wvalid;
    end else begin : g_w_pass
      assign m_axi.wvalid = s_axi.wvalid;
      assign s_axi.wready = m_axi.wready;
      assign w_w_out      = w_w_in;
      assign w_busy[1]    = 1'b0;
    end

    if (CUT_B) begin : g_b_cut
      axi4_skid_buf #(.T(b_chan_t)) u_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(m_axi.bvalid), .in_ready_o(m_axi.bready), .in_data_i(w_b_in),
        .out_valid_o(s_axi.bvalid), .out_ready_i(s_axi.bready), .out_data_o(w_b_out));
      assign w_busy[2] = s_axi.bvalid;
    end else begin : g_b_pass
      assign s_axi.bvalid = m_axi.bvalid;
      assign m_axi.bready = s_axi.bready;
      assign w_b_out      = w_b_in;
      assign w_busy[2]    = 1'b0;
    end

    if (CUT_AR) begin : g_ar_cut
      axi4_skid_buf #(.T(ar_chan_t)) u_ar (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(s_axi.arvalid), .in_ready_o(s_axi.arready), .in_data_i(w_ar_in),
        .out_valid_o(m_axi.arvalid), .out_ready_i(m_axi.arready), .out_data_o(w_ar_out));
      assign w_busy[3] = m_axi.arvalid;
    end else begin : g_ar_pass
      assign m_axi.arvalid = s_axi.arvalid;
      assign s_axi.arready = m_axi.arready;
      assign w_ar_out      = w_ar_in;
      assign w_busy[3]     = 1'b0;
    end

    if (CUT_R) begin : g_r_cut
      axi4_skid_buf #(.T(r_chan_t)) u_r (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(m_axi.rvalid), .in_ready_o(m_axi.rready), .in_data_i(w_r_in),
        .out_valid_o(s_axi.rvalid), .out_ready_i(s_axi.rready), .out_data_o(w_r_out));
      assign w_busy[4] = s_axi.rvalid;
    end else begin : g_r_pass
      assign s_axi.rvalid = m_axi.rvalid;
      assign m_axi.rready = s_axi.rready;
      assign w_r_out      = w_r_in;
      assign w_busy[4]    = 1'b0;
    end
  endgenerate
endmodule
